rx_buffer_ctrl: RTL and testbench
=================================

# rx_buffer_ctrl

Receive-side buffer controller for the UART receiver. It accepts each validated byte the receiver control unit announces with its single-cycle `load_buffer` strobe and stores it in a small FIFO, so back-to-back frames are not lost while the host is slow. It presents the oldest byte to the consumer with a ready/read handshake and flags overrun when a byte arrives with the FIFO full. It sits between the receiver's shift-register datapath and the host read interface.

## Interface

**Parameters**
- `DEPTH`, default 4: FIFO entries. Power of two, range 2–16.
- `DATA_W`, default 8: byte width.

**Ports**
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_buffer`  in  1  single-cycle strobe from the receiver control unit: `packet_data` holds a valid byte.
- `packet_data`  in  DATA_W  received byte; sampled only when `load_buffer`=1.
- `data_read`  in  1  consumer pulse: the current `rx_data` has been taken.
- `rx_data`  out  DATA_W  oldest stored byte, show-ahead; 0 when empty.
- `data_ready`  out  1  FIFO non-empty.
- `fifo_full`  out  1  count == DEPTH.
- `fifo_count`  out  $clog2(DEPTH)+1  number of stored bytes.
- `overrun_error`  out  1  sticky flag: a byte was dropped.

## Operation

- Storage: DEPTH×DATA_W register array, plus a write pointer and a read pointer, each $clog2(DEPTH) bits and wrapping naturally modulo DEPTH. A separate count register distinguishes full from empty. Full/empty must never be derived from pointer equality alone.
- Accepted push:
  - Condition: `load_buffer`=1 and (count<DEPTH or accepted pop in the same cycle).
  - Action: write `packet_data` at the write pointer, increment the write pointer.
- Accepted pop:
  - Condition: `data_read`=1 and count>0.
  - Action: increment the read pointer.
- Count update: +1 for a push only, −1 for a pop only, unchanged for both or neither.
- `data_read` with count=0 is ignored. No pointer move, no error.
- `load_buffer` with count=DEPTH and no accepted pop:
  - The byte is dropped.
  - Pointers and contents are unchanged.
  - `overrun_error` sets.
- `overrun_error` clearing:
  - Clears on the cycle after an accepted pop.
  - If a new overrun and an accepted pop occur in the same cycle, set wins.
- Simultaneous push and pop:
  - With count=0: only the push takes effect, because the pop is not accepted.
  - With count=DEPTH: both take effect, count stays DEPTH, no overrun.
- `rx_data` is driven from the entry at the read pointer. It is masked to 0 when count=0.
- `data_ready` = (count≠0). `fifo_full` = (count==DEPTH). Both are decoded from the registered count, not from next-state values.

## Timing

- Reset: on any `clk` edge with `rst`=1, set count=0, both pointers=0, `overrun_error`=0. Storage contents are don't-care.
  - Outputs after reset: `rx_data`=0, `data_ready`=0, `fifo_full`=0, `fifo_count`=0, `overrun_error`=0.
  - Reset overrides a concurrent `load_buffer` or `data_read`.
  - Reset mid-stream discards all stored bytes.
- Push latency: a byte strobed in cycle N appears on `rx_data` with `data_ready`=1 in cycle N+1, if the FIFO was empty.
- Pop latency: `data_read` in cycle N advances `rx_data` to the next byte in cycle N+1. If the FIFO becomes empty, `data_ready`=0 in N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely at any fill level.
- No combinational path from any input to any output. All outputs are decoded from registers.
- Pointer wrap: after DEPTH pushes, the write pointer returns to 0 with no bubble.

## Test plan

- Reset then idle:
  - Stimulus: assert `rst` 2 cycles with `load_buffer`=1 and `packet_data`=0xA5.
  - Required response: all outputs 0. One cycle after `rst` falls, still `data_ready`=0.
- Ordered fill/drain with DEPTH=4:
  - Stimulus: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required response: `fifo_full`=1 and `fifo_count`=4.
  - Stimulus: then 4 `data_read` pulses.
  - Required response: `rx_data` reads 0x11, 0x22, 0x33, 0x44, then `data_ready`=0 and `rx_data`=0.
- Overrun:
  - Stimulus: fill with 0x01–0x04, then push 0x55 with no read.
  - Required response: `overrun_error`=1 next cycle, count stays 4, head still 0x01.
  - Stimulus: one `data_read`.
  - Required response: `overrun_error`=0, head 0x02.
- Simultaneous push and pop at full:
  - Stimulus: at count=4, assert `load_buffer` (0x66) and `data_read` together.
  - Required response: count stays 4, `overrun_error` stays 0, and 0x66 is the last byte drained.
- Simultaneous push and pop at empty, plus read when empty:
  - Stimulus: `data_read` alone with count=0.
  - Required response: no change.
  - Stimulus: `load_buffer` (0x7E) with `data_read` at count=0.
  - Required response: count=1 and `rx_data`=0x7E next cycle.
- Wrap-around:
  - Stimulus: 10 interleaved push/pop pairs with incrementing data 0x80–0x89.
  - Required response: output order 0x80–0x89, count never exceeds 1, pointers wrap past 3 without loss.

Source files
------------

// File: rtl/rx_buffer_ctrl.sv
// rx_buffer_ctrl: receive-side byte FIFO between the UART receiver datapath and the host.
//
// Each byte announced by the single-cycle load_buffer strobe is stored. The oldest byte is
// presented show-ahead on rx_data, and the consumer acknowledges it with data_read. A byte
// that arrives while the FIFO is full, with no pop in the same cycle, is dropped and sets
// the sticky overrun_error flag.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, 2..16)
//   DATA_W        byte width
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   load_buffer   strobe: packet_data holds a valid byte
//   packet_data   received byte
//   data_read     consumer pulse: current rx_data has been taken
//   rx_data       oldest stored byte, 0 when empty
//   data_ready    FIFO non-empty
//   fifo_full     count == DEPTH
//   fifo_count    number of stored bytes
//   overrun_error sticky: a byte was dropped; cleared by an accepted pop
module rx_buffer_ctrl #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_buffer,
  input  logic [DATA_W-1:0]        packet_data,
  input  logic                     data_read,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     data_ready,
  output logic                     fifo_full,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun_error
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              overrun_q, overrun_d;

  logic empty, full;
  logic pop_ok, push_ok, drop;

  // Flags come from the registered count; pointer equality alone is ambiguous.
  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));

  // A push at full is still accepted when a pop frees the head slot in the same cycle.
  assign pop_ok  = data_read && !empty;
  assign push_ok = load_buffer && (!full || pop_ok);
  assign drop    = load_buffer && !push_ok;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    // A fresh drop takes priority over the clear from a pop.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (pop_ok) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= packet_data;
    end
  end

  always_comb begin
    rx_data = '0;
    if (!empty) begin
      rx_data = mem_q[rd_ptr_q];
    end
  end

  assign data_ready    = !empty;
  assign fifo_full     = full;
  assign fifo_count    = count_q;
  assign overrun_error = overrun_q;

endmodule

// File: tb/tb_rx_buffer_ctrl.sv
// Scoreboard bench for rx_buffer_ctrl. A queue-based reference model predicts the outputs
// after every clock edge; the driver pushes each prediction into a queue, and a separate
// monitor pops and compares on the falling edge.
module tb_rx_buffer_ctrl;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              load_buffer = 1'b0;
  logic [DATA_W-1:0] packet_data = '0;
  logic              data_read = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic              data_ready;
  logic              fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overrun_error;

  rx_buffer_ctrl #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_buffer   (load_buffer),
    .packet_data   (packet_data),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .fifo_full     (fifo_full),
    .fifo_count    (fifo_count),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned data;
    int unsigned ready;
    int unsigned full;
    int unsigned count;
    int unsigned ovr;
  } exp_t;

  exp_t        sb[$];
  int unsigned mq[$];   // model FIFO contents, oldest first
  bit          m_ovr;
  bit          armed;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares the DUT against the oldest outstanding prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("data_ready", 32'(data_ready), e.ready);
        chk("fifo_full", 32'(fifo_full), e.full);
        chk("fifo_count", 32'(fifo_count), e.count);
        chk("overrun_error", 32'(overrun_error), e.ovr);
        chk("rx_data", 32'(rx_data), e.data);
      end
    end
  end

  // One clock: record prediction for the state now visible, then apply inputs and advance model.
  task automatic cycle(input bit r, input bit ld, input int unsigned d, input bit rd);
    exp_t e;
    bit   pop_ok, push_ok;
    @(posedge clk);
    #1;
    if (armed) begin
      e.data  = (mq.size() > 0) ? mq[0] : 0;
      e.ready = (mq.size() > 0) ? 1 : 0;
      e.full  = (mq.size() == DEPTH) ? 1 : 0;
      e.count = mq.size();
      e.ovr   = m_ovr;
      sb.push_back(e);
    end
    rst         = r;
    load_buffer = ld;
    packet_data = DATA_W'(d);
    data_read   = rd;
    if (r) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      pop_ok  = rd && (mq.size() > 0);
      push_ok = ld && ((mq.size() < DEPTH) || pop_ok);
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d & ((1 << DATA_W) - 1));
      if (ld && !push_ok) m_ovr = 1'b1;
      else if (pop_ok) m_ovr = 1'b0;
    end
    armed = 1'b1;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0);
  endtask

  initial begin
    int unsigned ld_pct;
    int unsigned rd_pct;
    checks = 0;
    errors = 0;
    armed  = 1'b0;
    m_ovr  = 1'b0;

    // Reset with a concurrent load, then idle.
    cycle(1, 1, 'hA5, 0);
    cycle(1, 1, 'hA5, 0);
    idle();
    idle();

    // Ordered fill and drain.
    for (int i = 1; i <= 4; i++) cycle(0, 1, 'h11 * i, 0);
    idle();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    idle();

    // Overrun, then cleared by a pop.
    for (int i = 1; i <= 4; i++) cycle(0, 1, i, 0);
    cycle(0, 1, 'h55, 0);
    idle();
    cycle(0, 0, 0, 1);
    idle();
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    idle();

    // Simultaneous push and pop at full.
    for (int i = 1; i <= 4; i++) cycle(0, 1, 'h20 + i, 0);
    cycle(0, 1, 'h66, 1);
    idle();
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    idle();

    // Read when empty, then push+pop at empty.
    cycle(0, 0, 0, 1);
    idle();
    cycle(0, 1, 'h7E, 1);
    idle();
    cycle(0, 0, 0, 1);
    idle();

    // Wrap-around with interleaved push/pop.
    cycle(0, 1, 'h80, 0);
    for (int i = 1; i < 10; i++) cycle(0, 1, 'h80 + i, 1);
    cycle(0, 0, 0, 1);
    idle();

    // Reset mid-stream discards contents.
    for (int i = 0; i < 3; i++) cycle(0, 1, 'hC0 + i, 0);
    cycle(1, 0, 0, 0);
    idle();

    // Randomized phases with varying fill bias.
    for (int ph = 0; ph < 6; ph++) begin
      ld_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 50 : 20);
      rd_pct = 100 - ld_pct;
      for (int i = 0; i < 120; i++) begin
        cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < ld_pct),
              $urandom_range(0, 255), ($urandom_range(0, 99) < rd_pct));
      end
    end
    idle();
    idle();

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
